// File: rtl/array_resp.sv
`default_nettype none
// ============================================================================
// Module   : array_resp
// Purpose  : Memory-array bank model: row activate/precharge FSM, column
//            read/write into local storage, fixed-latency read response and
//            sticky timing/protocol error flags.
// Revision : 1.0
// ============================================================================
module array_resp #(
    parameter int COL_AW    = 6,
    parameter int ROW_AW    = 16,
    parameter int DW        = 64,
    parameter int ROWS_LOG2 = 2,
    parameter int RD_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              array_cs_n,
    input  logic [ROW_AW-1:0] array_raddr,
    input  logic              array_caddr_vld_wr,
    input  logic [COL_AW-1:0] array_caddr_wr,
    input  logic              array_caddr_vld_rd,
    input  logic [COL_AW-1:0] array_caddr_rd,
    input  logic              array_wdata_vld,
    input  logic [DW-1:0]     array_wdata,
    input  logic [7:0]        array_tRCD_WR,
    input  logic [7:0]        array_tRCD_RD,
    input  logic [7:0]        array_tRAS,
    input  logic [7:0]        array_tRP,
    input  logic              err_clr,
    output logic              array_rdata_vld,
    output logic [DW-1:0]     array_rdata,
    output logic              row_open,
    output logic [4:0]        err_flags
);

    localparam int C_MEM_AW = ROWS_LOG2 + COL_AW;
    localparam int C_DEPTH  = 1 << C_MEM_AW;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_act_cnt;
    logic [7:0]           r_pre_cnt;
    logic [7:0]           w_act_inc;
    logic [7:0]           w_pre_inc;
    logic [ROWS_LOG2-1:0] r_row;
    logic [4:0]           r_err;
    logic [4:0]           w_err_set;
    logic                 w_activate;
    logic                 w_precharge;
    logic                 w_wr_go;
    logic                 w_rd_go;
    logic                 w_col_any;
    logic                 w_col_bad;
    logic [DW-1:0]        w_rd_word;
    logic                 w_unused_raddr;

    logic [DW-1:0]        r_mem [C_DEPTH];
    logic [RD_LAT-1:0]    r_pipe_vld;
    logic [DW-1:0]        r_pipe_dat [RD_LAT];

    // Only the low row bits select storage; the rest are accepted but ignored.
    assign w_unused_raddr = ^array_raddr[ROW_AW-1:ROWS_LOG2];

    assign w_act_inc = (r_act_cnt == 8'hFF) ? r_act_cnt : r_act_cnt + 8'd1;
    assign w_pre_inc = (r_pre_cnt == 8'hFF) ? r_pre_cnt : r_pre_cnt + 8'd1;
    assign w_col_any = array_caddr_vld_wr | array_caddr_vld_rd;
    assign w_col_bad = (array_caddr_vld_wr & array_caddr_vld_rd) |
                       (array_caddr_vld_wr & ~array_wdata_vld);
    assign w_rd_word = r_mem[{r_row, array_caddr_rd}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_activate  = 1'b0;
        w_precharge = 1'b0;
        w_wr_go     = 1'b0;
        w_rd_go     = 1'b0;
        w_err_set   = 5'b0;
        case (r_state)
            S_IDLE: begin
                // Column commands are never executed while the row is closed,
                // including the activation cycle itself.
                w_err_set[3] = w_col_any;
                if (!array_cs_n) begin
                    w_state_nxt  = S_ACTIVE;
                    w_activate   = 1'b1;
                    w_err_set[2] = (r_pre_cnt < array_tRP);
                end
            end
            S_ACTIVE: begin
                if (!w_col_bad) begin
                    w_wr_go = array_caddr_vld_wr;
                    w_rd_go = array_caddr_vld_rd;
                    w_err_set[0] = (array_caddr_vld_wr && (r_act_cnt < array_tRCD_WR)) ||
                                   (array_caddr_vld_rd && (r_act_cnt < array_tRCD_RD));
                end
                if (array_cs_n) begin
                    w_state_nxt  = S_IDLE;
                    w_precharge  = 1'b1;
                    w_err_set[1] = (r_act_cnt < array_tRAS);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_err_set[4] = w_col_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_cnt <= 8'd0;
            r_pre_cnt <= 8'hFF;
            r_row     <= '0;
            r_err     <= 5'b0;
        end else begin
            if (w_activate) begin
                r_act_cnt <= 8'd0;
                r_row     <= array_raddr[ROWS_LOG2-1:0];
            end else if (r_state == S_ACTIVE) begin
                r_act_cnt <= w_act_inc;
            end
            if (w_precharge) begin
                r_pre_cnt <= 8'd0;
            end else if (r_state == S_IDLE) begin
                r_pre_cnt <= w_pre_inc;
            end
            // A new error in the clear cycle survives the clear.
            r_err <= (err_clr ? 5'b0 : r_err) | w_err_set;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            r_mem[{r_row, array_caddr_wr}] <= array_wdata;
        end
    end

    // Each stage only loads data when a valid word enters it, so the last
    // stage naturally holds the most recent response between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_go;
            if (w_rd_go) begin
                r_pipe_dat[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_dat[i] <= r_pipe_dat[i-1];
                end
            end
        end
    end

    assign array_rdata_vld = r_pipe_vld[RD_LAT-1];
    assign array_rdata     = r_pipe_dat[RD_LAT-1];
    assign row_open        = (r_state == S_ACTIVE);
    assign err_flags       = r_err;

endmodule
`default_nettype wire
